pzcorebus_response_fifo: RTL

PZCOREBUS_RESPONSE_FIFO -- requirements
Module: pzcorebus_response_fifo

---
 rtl/pzcorebus_response_fifo.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/pzcorebus_response_fifo.sv
// Response FIFO between a pzcorebus slave and master; 1-cycle latency, registered flags.
// PZCOREBUS_RESPONSE_FIFO_PACKET_COUNT_EN enables the stored-burst counter.
module pzcorebus_response_fifo #(
    parameter int RESPONSE_WIDTH = 32,
    parameter int DEPTH          = 2,
    parameter int THRESHOLD      = DEPTH
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_clear,
    input  logic                         i_sresp_valid,
    output logic                         o_mresp_accept,
    input  logic [RESPONSE_WIDTH-1:0]    i_sresp,
    input  logic                         i_sresp_last,
    output logic                         o_sresp_valid,
    input  logic                         i_mresp_accept,
    output logic [RESPONSE_WIDTH-1:0]    o_sresp,
    output logic                         o_sresp_last,
    output logic                         o_empty,
    output logic                         o_almost_full,
    output logic                         o_full,
    output logic [$clog2(DEPTH+1)-1:0]   o_word_count,
    output logic [$clog2(DEPTH+1)-1:0]   o_packet_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    if (DEPTH < 2) begin : g_bad_depth
        $error("DEPTH must be >= 2");
    end
    if (THRESHOLD < 1 || THRESHOLD > DEPTH) begin : g_bad_threshold
        $error("THRESHOLD must be in 1..DEPTH");
    end

    logic [RESPONSE_WIDTH:0] mem_q [DEPTH];
    logic [PW-1:0]           wptr_q, wptr_d;
    logic [PW-1:0]           rptr_q, rptr_d;
    logic [CW-1:0]           count_q, count_d;
    logic                    empty_q, empty_d;
    logic                    full_q, full_d;
    logic                    afull_q, afull_d;
    logic                    push;
    logic                    pop;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    assign o_mresp_accept = !full_q;
    assign o_sresp_valid  = !empty_q;
    assign push = i_sresp_valid && !full_q && !i_clear;
    assign pop  = !empty_q && i_mresp_accept && !i_clear;

    assign {o_sresp_last, o_sresp} = mem_q[rptr_q];

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_q[wptr_q] <= {i_sresp_last, i_sresp};
        end
    end

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (i_clear) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push) wptr_d = wrap_inc(wptr_q);
            if (pop)  rptr_d = wrap_inc(rptr_q);
            unique case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
        empty_d = (count_d == '0);
        full_d  = (count_d == CW'(DEPTH));
        afull_d = (count_d >= CW'(THRESHOLD));
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            afull_q <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            empty_q <= empty_d;
            full_q  <= full_d;
            afull_q <= afull_d;
        end
    end

    assign o_empty       = empty_q;
    assign o_full        = full_q;
    assign o_almost_full = afull_q;
    assign o_word_count  = count_q;

`ifdef PZCOREBUS_RESPONSE_FIFO_PACKET_COUNT_EN
    logic [CW-1:0] pcount_q, pcount_d;
    logic          pk_inc;
    logic          pk_dec;

    assign pk_inc = push && i_sresp_last;
    assign pk_dec = pop && o_sresp_last;

    always_comb begin
        pcount_d = pcount_q;
        if (i_clear) begin
            pcount_d = '0;
        end else begin
            unique case ({pk_inc, pk_dec})
                2'b10:   pcount_d = pcount_q + 1'b1;
                2'b01:   pcount_d = pcount_q - 1'b1;
                default: pcount_d = pcount_q;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            pcount_q <= '0;
        end else begin
            pcount_q <= pcount_d;
        end
    end

    assign o_packet_count = pcount_q;
`else
    assign o_packet_count = '0;
`endif

endmodule
